// File: rtl/key_status_tracker.sv
// ---------------------------------------------------------------------------
// key_status_tracker
//
// Upstream writer for the key-status display memory. Note on/off events from
// the sequencer are folded into a shadow copy of the display table (one 8-bit
// instrument mask per melodic key plus one drum mask). Each change is pushed
// to the display through a read-modify-write of the shadow copy, so the
// display memory needs no read port on this side.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset (highest priority)
//   clear       single-cycle pulse; restarts the zeroing sweep of the table
//   ev_valid    event present
//   ev_ready    event accepted when ev_valid && ev_ready
//   ev_on       1 = note on (set bit), 0 = note off (clear bit)
//   ev_is_drum  event targets the drum entry
//   ev_inst     instrument index (bit select for melodic events)
//   ev_key      melodic key; drum events use ev_key[2:0] as the bit index
//   wr_addr     display write address (display writes every cycle)
//   wr_data     display write data
//   busy        high while clearing or while an event is in flight
// ---------------------------------------------------------------------------
module key_status_tracker #(
    parameter int NUM_KEYS  = 48,
    parameter int DRUM_ADDR = 48
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       ev_valid,
    output logic       ev_ready,
    input  logic       ev_on,
    input  logic       ev_is_drum,
    input  logic [2:0] ev_inst,
    input  logic [5:0] ev_key,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam int         DEPTH     = DRUM_ADDR + 1;
    localparam logic [5:0] LAST_ADDR = 6'(DRUM_ADDR);
    localparam logic [5:0] KEY_LIMIT = 6'(NUM_KEYS);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_READ,
        ST_WRITE
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [5:0] cnt;
    logic [7:0] shadow [DEPTH];
    logic [7:0] rd_data;
    logic [7:0] new_data;

    // Latched event
    logic [5:0] ev_addr_q;
    logic [2:0] ev_bit_q;
    logic       ev_on_q;
    logic       ev_ok_q;

    // Decode of the incoming event
    logic       accept;
    logic [5:0] tgt_addr;
    logic [2:0] tgt_bit;
    logic       tgt_ok;

    // Modify step
    logic [7:0] bit_mask;
    logic [7:0] mod_data;

    // Shadow write port
    logic       mem_we;
    logic [5:0] mem_addr;
    logic [7:0] mem_wdata;

    // ------------------------------------------------------------------
    // Handshake and event decode
    // ------------------------------------------------------------------
    always_comb begin
        // ev_ready depends only on state and clear, never on ev_valid.
        ev_ready = (state == ST_IDLE) && !clear;
        busy     = (state != ST_IDLE);
        accept   = ev_valid && ev_ready;

        if (ev_is_drum) begin
            tgt_addr = LAST_ADDR;
            tgt_bit  = ev_key[2:0];
            tgt_ok   = 1'b1;
        end else begin
            tgt_addr = ev_key;
            tgt_bit  = ev_inst;
            tgt_ok   = (ev_key < KEY_LIMIT);
        end
    end

    always_comb begin
        bit_mask = 8'b1 << ev_bit_q;
        if (ev_on_q) begin
            mod_data = rd_data | bit_mask;
        end else begin
            mod_data = rd_data & ~bit_mask;
        end
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = ST_CLEAR;
        end else begin
            unique case (state)
                ST_CLEAR: begin
                    if (cnt == LAST_ADDR) begin
                        state_next = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        state_next = ST_READ;
                    end
                end
                ST_READ:  state_next = ST_WRITE;
                ST_WRITE: state_next = ST_IDLE;
                default:  state_next = ST_CLEAR;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: sweep counter, event latch, read/modify, display outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_data   <= '0;
            new_data  <= '0;
            ev_addr_q <= '0;
            ev_bit_q  <= '0;
            ev_on_q   <= 1'b0;
            ev_ok_q   <= 1'b0;
        end else if (clear) begin
            // Abandon any in-flight event; display outputs hold until the
            // sweep begins writing on the next cycle.
            cnt     <= '0;
            ev_ok_q <= 1'b0;
        end else begin
            unique case (state)
                ST_CLEAR: begin
                    wr_addr <= cnt;
                    wr_data <= '0;
                    if (cnt != LAST_ADDR) begin
                        cnt <= cnt + 6'd1;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        ev_addr_q <= tgt_addr;
                        ev_bit_q  <= tgt_bit;
                        ev_on_q   <= ev_on;
                        ev_ok_q   <= tgt_ok;
                        // Out-of-range keys are dropped; skip the read so
                        // the shadow array is never indexed past its end.
                        if (tgt_ok) begin
                            rd_data <= shadow[tgt_addr];
                        end
                    end
                end
                ST_READ: begin
                    new_data <= mod_data;
                end
                ST_WRITE: begin
                    if (ev_ok_q) begin
                        wr_addr <= ev_addr_q;
                        wr_data <= new_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Shadow memory write port
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = ev_addr_q;
        mem_wdata = new_data;
        if (!reset && !clear) begin
            if (state == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_addr  = cnt;
                mem_wdata = '0;
            end else if (state == ST_WRITE && ev_ok_q) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            shadow[mem_addr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_key_status_tracker.sv
module tb_key_status_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       ev_valid;
    logic       ev_ready;
    logic       ev_on;
    logic       ev_is_drum;
    logic [2:0] ev_inst;
    logic [5:0] ev_key;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    key_status_tracker #(.NUM_KEYS(48), .DRUM_ADDR(48)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_on      (ev_on),
        .ev_is_drum (ev_is_drum),
        .ev_inst    (ev_inst),
        .ev_key     (ev_key),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // Reference model: the display table and the last value on the write port.
    logic [7:0] model [0:48];
    logic [5:0] exp_addr;
    logic [7:0] exp_data;

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 49; i++) model[i] = 8'h00;
        exp_addr = 6'd48;
        exp_data = 8'h00;
    endfunction

    function automatic void model_apply(input bit on, input bit drum, input int inst, input int key);
        int addr;
        int bitn;
        int val;
        if (drum) begin
            addr = 48;
            bitn = key % 8;
        end else begin
            addr = key;
            bitn = inst;
        end
        if (drum || key < 48) begin
            val = model[addr];
            if (on) val = val | (1 << bitn);
            else    val = val & (255 - (1 << bitn));
            model[addr] = 8'(val);
            exp_addr    = 6'(addr);
            exp_data    = 8'(val);
        end
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (ev_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (ev_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready_timeout: ev_ready=%b after %0d cycles, required 1", tag, ev_ready, n);
        end
    endtask

    // Full zero sweep following a reset release or clear edge.
    task automatic check_sweep(input string tag);
        for (int i = 0; i < 49; i++) begin
            step();
            checks++;
            if (wr_addr !== 6'(i) || wr_data !== 8'h00) begin
                failures++;
                $display("FAIL %s_sweep[%0d]: got addr=%0d data=%h, required addr=%0d data=00",
                         tag, i, wr_addr, wr_data, i);
            end
            checks++;
            if (ev_ready !== (i == 48) || busy !== (i != 48)) begin
                failures++;
                $display("FAIL %s_sweep_hs[%0d]: got ready=%b busy=%b, required ready=%b busy=%b",
                         tag, i, ev_ready, busy, (i == 48), (i != 48));
            end
        end
        model_clear();
    endtask

    task automatic do_event(input bit on, input bit drum, input int inst, input int key, input string tag);
        wait_ready(tag);
        ev_valid   = 1'b1;
        ev_on      = on;
        ev_is_drum = drum;
        ev_inst    = 3'(inst);
        ev_key     = 6'(key);
        step();
        ev_valid = 1'b0;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (ev_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL %s_inflight%0d: got ready=%b busy=%b, required ready=0 busy=1",
                         tag, s, ev_ready, busy);
            end
            checks++;
            if (wr_addr !== exp_addr || wr_data !== exp_data) begin
                failures++;
                $display("FAIL %s_hold%0d: got addr=%0d data=%h, required addr=%0d data=%h",
                         tag, s, wr_addr, wr_data, exp_addr, exp_data);
            end
            if (s == 0) step();
        end
        model_apply(on, drum, inst, key);
        step();
        checks++;
        if (wr_addr !== exp_addr || wr_data !== exp_data) begin
            failures++;
            $display("FAIL %s_write: got addr=%0d data=%h, required addr=%0d data=%h",
                     tag, wr_addr, wr_data, exp_addr, exp_data);
        end
        checks++;
        if (ev_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_done: got ready=%b busy=%b, required ready=1 busy=0", tag, ev_ready, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (wr_addr !== 6'd0 || wr_data !== 8'h00 || ev_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: got addr=%0d data=%h ready=%b busy=%b, required 0 00 0 1",
                     wr_addr, wr_data, ev_ready, busy);
        end
        reset = 1'b0;
        check_sweep("reset");
    endtask

    task automatic test_melodic();
        do_event(1'b1, 1'b0, 3, 5, "mel_on3");
        do_event(1'b1, 1'b0, 0, 5, "mel_on0");
        do_event(1'b0, 1'b0, 3, 5, "mel_off3");
        do_event(1'b0, 1'b0, 3, 5, "mel_redundant_off");
        do_event(1'b1, 1'b0, 0, 5, "mel_redundant_on");
        do_event(1'b1, 1'b0, 7, 47, "mel_last_key");
    endtask

    task automatic test_drum();
        do_event(1'b1, 1'b1, 7, 8'h3A, "drum_on");
        do_event(1'b1, 1'b1, 0, 8'h07, "drum_on7");
        do_event(1'b0, 1'b1, 5, 8'h3A, "drum_off");
    endtask

    task automatic test_invalid_key();
        do_event(1'b1, 1'b0, 2, 50, "bad_key50");
        do_event(1'b1, 1'b0, 0, 48, "bad_key48");
        do_event(1'b1, 1'b0, 4, 63, "bad_key63");
    endtask

    task automatic test_back_to_back();
        int last_acc = 0;
        int acc;
        bit on, drum;
        int inst, key;
        ev_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            on   = 1'($urandom_range(0, 1));
            drum = ($urandom_range(0, 3) == 0);
            inst = $urandom_range(0, 7);
            key  = $urandom_range(0, 63);
            ev_on      = on;
            ev_is_drum = drum;
            ev_inst    = 3'(inst);
            ev_key     = 6'(key);
            wait_ready("b2b");
            acc = cycle;
            if (i > 0) begin
                checks++;
                if (acc - last_acc != 3) begin
                    failures++;
                    $display("FAIL b2b_spacing[%0d]: got %0d cycles, required 3", i, acc - last_acc);
                end
            end
            last_acc = acc;
            step();
            step();
            model_apply(on, drum, inst, key);
            step();
            checks++;
            if (wr_addr !== exp_addr || wr_data !== exp_data) begin
                failures++;
                $display("FAIL b2b_write[%0d]: got addr=%0d data=%h, required addr=%0d data=%h",
                         i, wr_addr, wr_data, exp_addr, exp_data);
            end
        end
        ev_valid = 1'b0;
    endtask

    task automatic test_clear();
        // Clear in the READ cycle abandons the event.
        do_event(1'b1, 1'b0, 1, 10, "clr_pre");
        wait_ready("clr_read");
        ev_on = 1'b1; ev_is_drum = 1'b0; ev_inst = 3'd6; ev_key = 6'd10;
        ev_valid = 1'b1;
        step();
        ev_valid = 1'b0;
        clear = 1'b1;
        #1;
        checks++;
        if (ev_ready !== 1'b0) begin
            failures++;
            $display("FAIL clr_read_ready: got %b, required 0", ev_ready);
        end
        step();
        clear = 1'b0;
        checks++;
        if (wr_addr !== exp_addr || wr_data !== exp_data) begin
            failures++;
            $display("FAIL clr_abandon: got addr=%0d data=%h, required addr=%0d data=%h",
                     wr_addr, wr_data, exp_addr, exp_data);
        end
        check_sweep("clr_read");
        do_event(1'b1, 1'b0, 4, 10, "clr_post");

        // Clear in IDLE with ev_valid high: ready is forced low.
        ev_valid = 1'b1;
        clear    = 1'b1;
        #1;
        checks++;
        if (ev_ready !== 1'b0) begin
            failures++;
            $display("FAIL clr_idle_ready: got %b, required 0", ev_ready);
        end
        step();
        clear    = 1'b0;
        ev_valid = 1'b0;
        check_sweep("clr_idle");

        // Clear during a sweep restarts it.
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 10; i++) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (wr_addr !== 6'd9 || busy !== 1'b1) begin
            failures++;
            $display("FAIL clr_restart_hold: got addr=%0d busy=%b, required addr=9 busy=1", wr_addr, busy);
        end
        check_sweep("clr_restart");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_event(1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                     $urandom_range(0, 7), $urandom_range(0, 63), "rand");
        end
    endtask

    initial begin
        reset      = 1'b1;
        clear      = 1'b0;
        ev_valid   = 1'b0;
        ev_on      = 1'b0;
        ev_is_drum = 1'b0;
        ev_inst    = '0;
        ev_key     = '0;
        model_clear();
        exp_addr   = 6'd0;

        test_reset();
        test_melodic();
        test_drum();
        test_invalid_key();
        test_back_to_back();
        test_clear();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
